// File: rtl/ddr3_ca_lane_ctrl.sv
// DDR3 command/address lane: 4-slot serialiser with 2T carry into the next word,
// plus a delay-line sequencer for load and stepwise relative tap moves.
module ddr3_ca_lane_ctrl (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       CMD_VALID,
    input  logic [1:0] CMD_PHASE,
    input  logic       CMD_BIT,
    input  logic       CMD_2T,
    input  logic       IDLE_LEVEL,
    input  logic       DRIVE_EN,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    input  logic       DLY_REQ,
    input  logic       DLY_DIR,
    input  logic [7:0] DLY_STEPS,
    input  logic       DLY_LOAD_REQ,
    output logic       DLY_BUSY,
    output logic       DLY_DONE,
    output logic       DLY_ERR,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0
);

    typedef enum logic [2:0] {IDLE, LOAD, MOVE, GAP, DONE} dly_state_t;

    // ---------------- CA data path ----------------
    logic [3:0] word_d;
    logic       carry_d;
    logic       carry_q;
    logic       carry_bit_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        word_d = {4{IDLE_LEVEL}};
        if (CMD_VALID) begin
            word_d[CMD_PHASE] = CMD_BIT;
            if (CMD_2T && (CMD_PHASE != 2'd3)) begin
                word_d[CMD_PHASE + 2'd1] = CMD_BIT;
            end
        end
        // A 2T bit spilled from slot 3 owns slot 0 of this word over any new command.
        if (carry_q) begin
            word_d[0] = carry_bit_q;
        end
        carry_d = CMD_VALID && CMD_2T && (CMD_PHASE == 2'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            TX_DATA_0   <= 4'b0000;
            OE_DATA_0   <= 4'b0000;
            carry_q     <= 1'b0;
            carry_bit_q <= 1'b0;
        end else begin
            TX_DATA_0   <= word_d;
            OE_DATA_0   <= {4{DRIVE_EN}};
            carry_q     <= carry_d;
            carry_bit_q <= CMD_BIT;
        end
    end

    // ---------------- delay-line sequencer ----------------
    dly_state_t state_q, state_d;
    logic [7:0] steps_q, steps_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= IDLE;
            steps_q <= 8'd0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (DLY_LOAD_REQ) begin
                    err_d   = 1'b0;
                    state_d = LOAD;
                end else if (DLY_REQ) begin
                    err_d = 1'b0;
                    if (DLY_STEPS != 8'd0) begin
                        steps_d = DLY_STEPS;
                        dir_d   = DLY_DIR;
                        state_d = MOVE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: state_d = DONE;
            MOVE: begin
                if (steps_q != 8'd0) begin
                    steps_d = steps_q - 8'd1;
                end
                state_d = GAP;
            end
            GAP: begin
                if (DELAY_LINE_OUT_OF_RANGE_0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (steps_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = MOVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so reset clears them at once.
    assign DLY_BUSY               = (state_q != IDLE);
    assign DLY_DONE               = (state_q == DONE);
    assign DLY_ERR                = err_q;
    assign DELAY_LINE_MOVE_0      = (state_q == MOVE);
    assign DELAY_LINE_LOAD_0      = (state_q == LOAD);
    assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr3_ca_lane_ctrl.sv
// Bench for ddr3_ca_lane_ctrl: a timeline model of slot words and delay sequences is
// compared every cycle, and directed scenarios pin the model with literal values.
module tb_ddr3_ca_lane_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N  = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic [1:0] CMD_PHASE = 2'd0;
    logic       CMD_BIT = 1'b0;
    logic       CMD_2T = 1'b0;
    logic       IDLE_LEVEL = 1'b0;
    logic       DRIVE_EN = 1'b0;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       DLY_REQ = 1'b0;
    logic       DLY_DIR = 1'b0;
    logic [7:0] DLY_STEPS = 8'd0;
    logic       DLY_LOAD_REQ = 1'b0;
    logic       DLY_BUSY;
    logic       DLY_DONE;
    logic       DLY_ERR;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

    ddr3_ca_lane_ctrl dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .CMD_VALID                 (CMD_VALID),
        .CMD_PHASE                 (CMD_PHASE),
        .CMD_BIT                   (CMD_BIT),
        .CMD_2T                    (CMD_2T),
        .IDLE_LEVEL                (IDLE_LEVEL),
        .DRIVE_EN                  (DRIVE_EN),
        .TX_DATA_0                 (TX_DATA_0),
        .OE_DATA_0                 (OE_DATA_0),
        .DLY_REQ                   (DLY_REQ),
        .DLY_DIR                   (DLY_DIR),
        .DLY_STEPS                 (DLY_STEPS),
        .DLY_LOAD_REQ              (DLY_LOAD_REQ),
        .DLY_BUSY                  (DLY_BUSY),
        .DLY_DONE                  (DLY_DONE),
        .DLY_ERR                   (DLY_ERR),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A delay request is a timeline of busy cycles numbered 1..m_len: a move of N steps
    // strobes on odd cycles and settles on even ones; out-of-range in a settle cycle
    // shortens the timeline so the following cycle is the done cycle.
    localparam int K_MOVE = 0;
    localparam int K_LOAD = 1;
    localparam int K_ZERO = 2;

    logic [3:0] m_tx = 4'b0000;
    logic [3:0] m_oe = 4'b0000;
    bit m_carry = 1'b0, m_carry_bit = 1'b0;
    bit m_active = 1'b0, m_dir = 1'b0, m_err = 1'b0;
    int m_k = 0, m_len = 0, m_kind = K_ZERO, m_p = 0;

    always @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            m_tx = 4'b0000; m_oe = 4'b0000;
            m_carry = 1'b0; m_carry_bit = 1'b0;
            m_active = 1'b0; m_dir = 1'b0; m_err = 1'b0;
            m_k = 0; m_len = 0;
        end else begin
            m_p = int'(CMD_PHASE);
            for (int s = 0; s < 4; s++) begin
                m_tx[s] = IDLE_LEVEL;
                if (CMD_VALID && (s == m_p || (CMD_2T && s == m_p + 1))) m_tx[s] = CMD_BIT;
                if (s == 0 && m_carry) m_tx[s] = m_carry_bit;
            end
            m_oe = {4{DRIVE_EN}};
            m_carry = CMD_VALID && CMD_2T && (m_p == 3);
            m_carry_bit = CMD_BIT;

            if (m_active) begin
                if (m_kind == K_MOVE && (m_k % 2) == 0 && m_k < m_len && DELAY_LINE_OUT_OF_RANGE_0) begin
                    m_err = 1'b1;
                    m_len = m_k + 1;
                end
                if (m_k == m_len) m_active = 1'b0;
                else m_k++;
            end else if (DLY_LOAD_REQ) begin
                m_active = 1'b1; m_k = 1; m_len = 2; m_kind = K_LOAD; m_err = 1'b0;
            end else if (DLY_REQ) begin
                m_active = 1'b1; m_k = 1; m_err = 1'b0;
                if (DLY_STEPS == 8'd0) begin
                    m_kind = K_ZERO; m_len = 1;
                end else begin
                    m_kind = K_MOVE; m_len = 2 * int'(DLY_STEPS) + 1; m_dir = DLY_DIR;
                end
            end
        end
    end

    always @(negedge FAB_CLK) begin
        if (started) begin
            check("cmp_tx",   32'(TX_DATA_0), 32'(m_tx));
            check("cmp_oe",   32'(OE_DATA_0), 32'(m_oe));
            check("cmp_busy", 32'(DLY_BUSY), 32'(m_active));
            check("cmp_move", 32'(DELAY_LINE_MOVE_0),
                  32'(m_active && m_kind == K_MOVE && (m_k % 2) == 1 && m_k < m_len));
            check("cmp_load", 32'(DELAY_LINE_LOAD_0), 32'(m_active && m_kind == K_LOAD && m_k == 1));
            check("cmp_done", 32'(DLY_DONE), 32'(m_active && m_k == m_len));
            check("cmp_dir",  32'(DELAY_LINE_DIRECTION_0), 32'(m_dir));
            check("cmp_err",  32'(DLY_ERR), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge FAB_CLK);
        #2;
    endtask

    task automatic cmd(input logic v, input logic [1:0] p, input logic b, input logic t,
                       input logic idle, input logic drv);
        CMD_VALID = v; CMD_PHASE = p; CMD_BIT = b; CMD_2T = t; IDLE_LEVEL = idle; DRIVE_EN = drv;
    endtask

    // Caller has set the request inputs; this launches them for one cycle and records
    // per-cycle strobes, bit k-1 holding cycle k after acceptance.
    task automatic capture(input int n, input int oor_cycle, input int inject_cycle,
                           output logic [15:0] mv, output logic [15:0] dn,
                           output logic [15:0] bs, output logic [15:0] ld);
        mv = '0; dn = '0; bs = '0; ld = '0;
        cyc(1);
        DLY_REQ = 1'b0; DLY_LOAD_REQ = 1'b0;
        for (int k = 1; k <= n; k++) begin
            mv[k-1] = DELAY_LINE_MOVE_0;
            dn[k-1] = DLY_DONE;
            bs[k-1] = DLY_BUSY;
            ld[k-1] = DELAY_LINE_LOAD_0;
            DELAY_LINE_OUT_OF_RANGE_0 = (k == oor_cycle);
            if (k == inject_cycle) begin
                DLY_REQ = 1'b1; DLY_LOAD_REQ = 1'b1; DLY_STEPS = 8'd7; DLY_DIR = 1'b0;
            end else begin
                DLY_REQ = 1'b0; DLY_LOAD_REQ = 1'b0;
            end
            cyc(1);
        end
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        DLY_REQ = 1'b0; DLY_LOAD_REQ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] mv, dn, bs, ld;

    initial begin
        #1 ARST_N = 1'b0;
        #1;
        check("rst_tx",   32'(TX_DATA_0), 32'h0);
        check("rst_oe",   32'(OE_DATA_0), 32'h0);
        check("rst_busy", 32'(DLY_BUSY), 32'h0);
        check("rst_done", 32'(DLY_DONE), 32'h0);
        check("rst_err",  32'(DLY_ERR), 32'h0);
        check("rst_move", 32'(DELAY_LINE_MOVE_0), 32'h0);
        check("rst_dir",  32'(DELAY_LINE_DIRECTION_0), 32'h0);
        check("rst_load", 32'(DELAY_LINE_LOAD_0), 32'h0);
        started = 1'b1;
        cyc(2);
        ARST_N = 1'b1;

        // Slot mapping, idle level, 2T and carry behaviour
        cmd(1, 2'd2, 1, 0, 0, 1); cyc(1);
        check("single_tx", 32'(TX_DATA_0), 32'b0100);
        check("single_oe", 32'(OE_DATA_0), 32'b1111);
        cmd(0, 2'd0, 0, 0, 1, 1); cyc(1);
        check("idle_tx", 32'(TX_DATA_0), 32'b1111);
        cmd(1, 2'd0, 0, 0, 1, 0); cyc(1);
        check("slot0_tx", 32'(TX_DATA_0), 32'b1110);
        check("oe_off",   32'(OE_DATA_0), 32'b0000);
        cmd(1, 2'd1, 0, 1, 1, 1); cyc(1);
        check("twot_tx", 32'(TX_DATA_0), 32'b1001);
        cmd(1, 2'd3, 1, 1, 0, 1); cyc(1);
        check("wrap_tx", 32'(TX_DATA_0), 32'b1000);
        cmd(1, 2'd0, 0, 0, 0, 1); cyc(1);
        check("carry_prio_tx", 32'(TX_DATA_0), 32'b0001);
        cmd(1, 2'd3, 1, 1, 0, 1); cyc(1);
        check("wrap2_tx", 32'(TX_DATA_0), 32'b1000);
        cmd(1, 2'd2, 1, 0, 0, 1); cyc(1);
        check("carry_merge_tx", 32'(TX_DATA_0), 32'b0101);
        cmd(1, 2'd3, 0, 1, 1, 1); cyc(1);
        check("wrap_low_tx", 32'(TX_DATA_0), 32'b0111);
        cmd(0, 2'd0, 0, 0, 1, 1); cyc(1);
        check("carry_low_tx", 32'(TX_DATA_0), 32'b1110);
        cmd(0, 2'd0, 0, 0, 0, 1); cyc(1);
        check("quiet_tx", 32'(TX_DATA_0), 32'b0000);

        // Three-step increasing move
        DLY_REQ = 1'b1; DLY_DIR = 1'b1; DLY_STEPS = 8'd3;
        capture(10, 0, 0, mv, dn, bs, ld);
        check("mv3_moves", 32'(mv), 32'h0015);
        check("mv3_done",  32'(dn), 32'h0040);
        check("mv3_busy",  32'(bs), 32'h007F);
        check("mv3_load",  32'(ld), 32'h0000);
        check("mv3_dir",   32'(DELAY_LINE_DIRECTION_0), 32'h1);
        check("mv3_err",   32'(DLY_ERR), 32'h0);

        // Out-of-range during the second settle cycle
        DLY_REQ = 1'b1; DLY_DIR = 1'b0; DLY_STEPS = 8'd10;
        capture(10, 4, 0, mv, dn, bs, ld);
        check("oor_moves", 32'(mv), 32'h0005);
        check("oor_done",  32'(dn), 32'h0010);
        check("oor_busy",  32'(bs), 32'h001F);
        check("oor_err",   32'(DLY_ERR), 32'h1);
        check("oor_dir",   32'(DELAY_LINE_DIRECTION_0), 32'h0);

        // Zero-step request clears the error and completes at once
        DLY_REQ = 1'b1; DLY_STEPS = 8'd0;
        capture(3, 0, 0, mv, dn, bs, ld);
        check("zero_done",  32'(dn), 32'h0001);
        check("zero_busy",  32'(bs), 32'h0001);
        check("zero_moves", 32'(mv), 32'h0000);
        check("zero_err",   32'(DLY_ERR), 32'h0);

        // Load wins over a simultaneous move request
        DLY_REQ = 1'b1; DLY_LOAD_REQ = 1'b1; DLY_STEPS = 8'd4; DLY_DIR = 1'b1;
        capture(4, 0, 0, mv, dn, bs, ld);
        check("prio_load",  32'(ld), 32'h0001);
        check("prio_moves", 32'(mv), 32'h0000);
        check("prio_done",  32'(dn), 32'h0002);
        check("prio_busy",  32'(bs), 32'h0003);

        // Requests arriving in the done cycle are dropped
        DLY_REQ = 1'b1; DLY_DIR = 1'b1; DLY_STEPS = 8'd2;
        capture(8, 0, 5, mv, dn, bs, ld);
        check("ign_moves", 32'(mv), 32'h0005);
        check("ign_done",  32'(dn), 32'h0010);
        check("ign_busy",  32'(bs), 32'h001F);
        check("ign_load",  32'(ld), 32'h0000);
        check("ign_dir",   32'(DELAY_LINE_DIRECTION_0), 32'h1);

        // Reset in a settle cycle aborts silently; the next request runs normally
        cmd(0, 2'd0, 0, 0, 1, 1);
        DLY_REQ = 1'b1; DLY_DIR = 1'b1; DLY_STEPS = 8'd5;
        cyc(1);
        DLY_REQ = 1'b0;
        cyc(1);
        check("pre_rst_busy", 32'(DLY_BUSY), 32'h1);
        ARST_N = 1'b0;
        #1;
        check("arst_tx",   32'(TX_DATA_0), 32'h0);
        check("arst_oe",   32'(OE_DATA_0), 32'h0);
        check("arst_busy", 32'(DLY_BUSY), 32'h0);
        check("arst_done", 32'(DLY_DONE), 32'h0);
        check("arst_move", 32'(DELAY_LINE_MOVE_0), 32'h0);
        check("arst_dir",  32'(DELAY_LINE_DIRECTION_0), 32'h0);
        cyc(2);
        ARST_N = 1'b1;
        DLY_REQ = 1'b1; DLY_DIR = 1'b1; DLY_STEPS = 8'd1;
        capture(5, 0, 0, mv, dn, bs, ld);
        check("post_moves", 32'(mv), 32'h0001);
        check("post_done",  32'(dn), 32'h0004);
        check("post_busy",  32'(bs), 32'h0007);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
